// File: rtl/key_digit_display_pkg.sv
// Shared constants for the key-entry digit display: key codes and
// active-low 7-segment patterns, bit order {dp,g,f,e,d,c,b,a}.
package key_digit_display_pkg;

  localparam logic [3:0] KEY_BACKSPACE = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/key_digit_display_seg7_decode.sv
// BCD to active-low 7-segment decoder; non-BCD codes blank the digit.
module seg7_decode
  import key_digit_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/key_digit_display.sv
// Keypad digit entry buffer with a free-running multiplexed 7-segment scan.
// Digit 0 is the most recent entry and sits in the low nibble of value.
module key_digit_display
  import key_digit_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 8
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  key_clear,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic [3:0]            count,
  output logic                  full
);

  localparam logic [3:0]  DIG_CNT   = 4'(DIGITS);
  localparam logic [2:0]  SCAN_MAX  = 3'(DIGITS - 1);
  localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

  logic [4*DIGITS-1:0] buf_q, buf_d;
  logic [3:0]          count_q, count_d;
  logic [19:0]         presc_q, presc_d;
  logic [2:0]          scan_q, scan_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [3:0]          digit_sel;
  logic [7:0]          seg_dec;

  // key_clear dominates, so a key arriving in the same cycle is dropped
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    if (key_clear) begin
      buf_d   = '0;
      count_d = 4'd0;
    end else if (key_valid) begin
      if (key_code <= 4'd9) begin
        buf_d = {buf_q[4*DIGITS-5:0], key_code};
        if (count_q != DIG_CNT) count_d = count_q + 4'd1;
      end else if (key_code == KEY_BACKSPACE) begin
        if (count_q != 4'd0) begin
          buf_d   = {4'h0, buf_q[4*DIGITS-1:4]};
          count_d = count_q - 4'd1;
        end
      end else if (key_code == KEY_CLEAR) begin
        buf_d   = '0;
        count_d = 4'd0;
      end
    end
  end

  always_comb begin
    presc_d = presc_q + 20'd1;
    scan_d  = scan_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = 20'd0;
      scan_d  = (scan_q == SCAN_MAX) ? 3'd0 : scan_q + 3'd1;
    end
  end

  always_comb begin
    digit_sel = 4'h0;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_q == 3'(i)) begin
        digit_sel = buf_q[4*i +: 4];
        an_d[i]   = 1'b0;
      end
    end
  end

  seg7_decode u_seg7_decode (
    .bcd_i (digit_sel),
    .seg_o (seg_dec)
  );

  // digits at or above count are leading positions and stay dark
  always_comb begin
    seg_d = ({1'b0, scan_q} < count_q) ? seg_dec : SEG_BLANK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q   <= '0;
      count_q <= 4'd0;
      presc_q <= 20'd0;
      scan_q  <= 3'd0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      presc_q <= presc_d;
      scan_q  <= scan_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign value = buf_q;
  assign count = count_q;
  assign full  = (count_q == DIG_CNT);

endmodule

// File: tb/tb_key_digit_display.sv
// Directed bench for key_digit_display with DIGITS=8 and a fast SCAN_DIV=4 scan.
module tb_key_digit_display;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_clear;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [31:0] value;
  logic [3:0]  count;
  logic        full;

  int nvec;
  int nerr;

  key_digit_display #(.SCAN_DIV(4), .DIGITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_clear (key_clear),
    .seg       (seg),
    .an        (an),
    .value     (value),
    .count     (count),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  code;
    logic        clr;
    logic [31:0] val;
    logic [3:0]  cnt;
    logic        full;
  } vec_t;

  vec_t vecs[40];
  int   nvecs;

  task automatic add(input logic kv, input logic [3:0] code, input logic clr,
                     input logic [31:0] val, input logic [3:0] cnt, input logic f);
    vecs[nvecs].kv   = kv;
    vecs[nvecs].code = code;
    vecs[nvecs].clr  = clr;
    vecs[nvecs].val  = val;
    vecs[nvecs].cnt  = cnt;
    vecs[nvecs].full = f;
    nvecs++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_an(input logic [7:0] tgt);
    int k;
    k = 0;
    while (an !== tgt && k < 100) begin
      tick();
      k++;
    end
    if (an !== tgt) begin
      nvec++;
      nerr++;
      $display("FAIL wait_an timeout: got %h expected %h", an, tgt);
    end
  endtask

  initial begin
    logic [7:0] exp_an;
    nvec  = 0;
    nerr  = 0;
    nvecs = 0;

    add(1'b1, 4'h1, 1'b0, 32'h00000001, 4'd1, 1'b0);
    add(1'b1, 4'h2, 1'b0, 32'h00000012, 4'd2, 1'b0);
    add(1'b1, 4'h3, 1'b0, 32'h00000123, 4'd3, 1'b0);
    add(1'b1, 4'hC, 1'b0, 32'h00000123, 4'd3, 1'b0);
    add(1'b1, 4'hF, 1'b0, 32'h00000123, 4'd3, 1'b0);
    add(1'b0, 4'h5, 1'b0, 32'h00000123, 4'd3, 1'b0);
    add(1'b1, 4'hA, 1'b0, 32'h00000012, 4'd2, 1'b0);
    add(1'b1, 4'hB, 1'b0, 32'h00000000, 4'd0, 1'b0);
    add(1'b1, 4'hA, 1'b0, 32'h00000000, 4'd0, 1'b0);
    add(1'b1, 4'h4, 1'b0, 32'h00000004, 4'd1, 1'b0);
    add(1'b1, 4'h5, 1'b0, 32'h00000045, 4'd2, 1'b0);
    add(1'b1, 4'hA, 1'b0, 32'h00000004, 4'd1, 1'b0);
    add(1'b1, 4'h7, 1'b1, 32'h00000000, 4'd0, 1'b0);
    add(1'b1, 4'h6, 1'b0, 32'h00000006, 4'd1, 1'b0);
    add(1'b0, 4'h0, 1'b1, 32'h00000000, 4'd0, 1'b0);
    add(1'b1, 4'h1, 1'b0, 32'h00000001, 4'd1, 1'b0);
    add(1'b1, 4'h2, 1'b0, 32'h00000012, 4'd2, 1'b0);
    add(1'b1, 4'h3, 1'b0, 32'h00000123, 4'd3, 1'b0);
    add(1'b1, 4'h4, 1'b0, 32'h00001234, 4'd4, 1'b0);
    add(1'b1, 4'h5, 1'b0, 32'h00012345, 4'd5, 1'b0);
    add(1'b1, 4'h6, 1'b0, 32'h00123456, 4'd6, 1'b0);
    add(1'b1, 4'h7, 1'b0, 32'h01234567, 4'd7, 1'b0);
    add(1'b1, 4'h8, 1'b0, 32'h12345678, 4'd8, 1'b1);
    add(1'b1, 4'h9, 1'b0, 32'h23456789, 4'd8, 1'b1);
    add(1'b1, 4'h0, 1'b0, 32'h34567890, 4'd8, 1'b1);
    add(1'b1, 4'hA, 1'b0, 32'h03456789, 4'd7, 1'b0);
    add(1'b1, 4'hB, 1'b0, 32'h00000000, 4'd0, 1'b0);

    // reset values, with a key already waiting for the first edge after release
    reset     = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h5;
    key_clear = 1'b0;
    #12;
    check("rst seg", seg, 8'hFF);
    check("rst an", an, 8'hFF);
    check("rst count", count, 4'd0);
    check("rst value", value, 32'h0);
    check("rst full", full, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      tick();
      exp_an = 8'hFF;
      exp_an[((n - 1) / 4) % 8] = 1'b0;
      check($sformatf("scan an edge %0d", n), an, exp_an);
      if (n == 1) begin
        key_valid = 1'b0;
        check("first edge seg", seg, 8'hFF);
        check("first edge value", value, 32'h5);
        check("first edge count", count, 4'd1);
      end
      if (n == 2) check("slot0 seg digit 5", seg, 8'h92);
      if (n == 10) begin
        key_valid = 1'b1;
        key_code  = 4'h7;
      end
      if (n == 11) begin
        key_valid = 1'b0;
        check("mid-scan key value", value, 32'h57);
        check("mid-scan key count", count, 4'd2);
      end
    end

    // asynchronous reset between edges, prescaler mid-count
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async rst seg", seg, 8'hFF);
    check("async rst an", an, 8'hFF);
    check("async rst count", count, 4'd0);
    check("async rst value", value, 32'h0);
    check("async rst full", full, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < nvecs; i++) begin
      key_valid = vecs[i].kv;
      key_code  = vecs[i].code;
      key_clear = vecs[i].clr;
      tick();
      key_valid = 1'b0;
      key_clear = 1'b0;
      check($sformatf("vec %0d value", i), value, vecs[i].val);
      check($sformatf("vec %0d count", i), count, vecs[i].cnt);
      check($sformatf("vec %0d full", i), full, vecs[i].full);
    end

    // displayed content for entry 1,2,3
    press(4'h1);
    press(4'h2);
    press(4'h3);
    check("123 value", value[11:0], 12'h123);
    check("123 count", count, 4'd3);
    wait_an(8'hFE);
    check("slot0 seg", seg, 8'hB0);
    wait_an(8'hFD);
    check("slot1 seg", seg, 8'hA4);
    wait_an(8'hFB);
    check("slot2 seg", seg, 8'hF9);
    wait_an(8'hF7);
    check("slot3 seg blank", seg, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/key_digit_display.md
KEY_DIGIT_DISPLAY -- requirements
Module: key_digit_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit scan slot (1 kHz at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter DIGITS, default 8, meaning the number of display digits and the buffer depth; legal range 2..8.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_valid, input, 1 bit: one-cycle strobe marking key_code as valid; it comes from the PS/2 decode stage.
REQ-006 SHALL have port key_code, input, 4 bits: 0-9 = digit, 4'hA = backspace, 4'hB = clear; 4'hC-4'hF are ignored.
REQ-007 SHALL have port key_clear, input, 1 bit: synchronous clear request, level-sampled every cycle.
REQ-008 SHALL have port seg, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}; dp SHALL always be 1 (off).
REQ-009 SHALL have port an, output, DIGITS bits: active-low one-hot digit enable.
REQ-010 SHALL have port value, output, 4*DIGITS bits: BCD buffer; digit 0 (most recent) is in bits [3:0].
REQ-011 SHALL have port count, output, 4 bits: number of entered digits, range 0..DIGITS.
REQ-012 SHALL have port full, output, 1 bit: high when count == DIGITS.

Function
REQ-013 On a cycle with key_valid=1 and key_code 0-9 while count<DIGITS, the buffer SHALL shift up one digit, load key_code into digit 0, and increment count.
REQ-014 On a digit key with count==DIGITS, the buffer SHALL still shift (the oldest digit is lost), load the new digit, and count SHALL remain DIGITS.
REQ-015 On backspace with count>0, the buffer SHALL shift down one digit, the top digit SHALL become 0, and count SHALL decrement.
REQ-016 On backspace with count==0, the block SHALL do nothing.
REQ-017 On key_code 4'hB, or key_clear=1, the buffer SHALL be set to all 0 and count to 0.
REQ-018 If key_clear=1 and key_valid=1 in the same cycle, the clear SHALL take effect and the key SHALL be discarded.
REQ-019 Codes 4'hC-4'hF SHALL leave all state unchanged.
REQ-020 value, count and full SHALL update on the clock edge that samples key_valid: 1-cycle latency, registered outputs.
REQ-021 A prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-022 On each wrap, the scan index SHALL advance by 1, modulo DIGITS.
REQ-023 an SHALL drive 0 only at the bit equal to the scan index.
REQ-024 seg SHALL show the 7-segment pattern of buffer[scan index] when scan index < count; otherwise seg SHALL be 8'hFF (blank leading digits).
REQ-025 With count==0, all digits SHALL be blank.
REQ-026 seg and an SHALL be registered and SHALL lag the scan index, buffer or count change by exactly 1 cycle.
REQ-027 Key events SHALL NOT reset or stall the scan; the scan SHALL run continuously.

Reset
REQ-028 With reset=0, the block SHALL asynchronously force: buffer 0, count 0, full 0, prescaler 0, scan index 0, seg 8'hFF, an all 1.
REQ-029 A reset asserted mid-scan or mid-key SHALL discard any pending key.
REQ-030 After reset is released, the first edge SHALL load an bit 0 low with seg 8'hFF.
REQ-031 No key_valid pulse SHALL be missed from the first edge after reset release.

Structure
REQ-032 A shared package SHALL hold the key code constants: KEY_BACKSPACE = 4'hA and KEY_CLEAR = 4'hB.
REQ-033 The same package SHALL hold the active-low segment constants for 0-9 and SEG_BLANK = 8'hFF.
REQ-034 A single combinational sub-module seg7_decode (4-bit BCD in, 8-bit active-low seg out; codes above 9 give blank) SHALL be instantiated once, on the scan-multiplexed digit.

Verification
REQ-035 SHALL check: reset, then keys 1,2,3 -> value[11:0]=12'h123, count=3; an bit 0 slot shows 3 (seg 8'hB0) and an bit 3 slot shows 8'hFF.
REQ-036 SHALL check: enter 9 digits 1..9 with DIGITS=8 -> value=32'h23456789, count=8, full=1.
REQ-037 SHALL check: backspace on empty -> count=0, no change; backspace after 4,5 -> value[3:0]=4, count=1.
REQ-038 SHALL check: key_valid=1 with code 7 and key_clear=1 in the same cycle -> value=0, count=0.
REQ-039 SHALL check: SCAN_DIV=4 -> an steps FE,FD,FB,... every 4 cycles and wraps after 8 slots; a key press does not perturb the step timing.
REQ-040 SHALL check: reset asserted asynchronously mid-prescale -> seg=8'hFF, an all 1, count=0 with no clock edge.
